// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse constants and the init-sequencer state encoding.
// The state values are visible on the debug LED port, so they are fixed here.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] RATE_100     = 8'h64;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_ERR    = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] ID_MOUSE   = 8'h00;

  localparam logic [1:0] CMD_LAST = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SEND     = 4'd1,
    ST_WAIT_TX  = 4'd2,
    ST_WAIT_ACK = 4'd3,
    ST_WAIT_BAT = 4'd4,
    ST_WAIT_ID  = 4'd5,
    ST_RETRY    = 4'd6,
    ST_NEXT     = 4'd7,
    ST_DONE     = 4'd8,
    ST_FAIL     = 4'd9
  } ps2_state_e;

  // Init command sequence: reset, set sample rate to 100 Hz, enable reporting.
  function automatic logic [7:0] cmd_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_RESET;
      2'd1:    return CMD_SET_RATE;
      2'd2:    return RATE_100;
      default: return CMD_ENABLE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_start_sync.sv
// Two-flop synchronizer and falling-edge detector for the active-low start key.
// Emits a one-cycle registered pulse per press.
module ps2_start_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic start_edge
);

  logic [1:0] sync;
  logic       sync_d;

  // Sync stages reset to 1 so a released key produces no spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= 2'b11;
      sync_d     <= 1'b1;
      start_edge <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sync       <= {sync[0], key_n};
      sync_d     <= sync[1];
      start_edge <= sync_d & ~sync[1];
    end
  end

endmodule

// File: rtl/ps2_init_sequencer.sv
// PS/2 mouse init controller: sends FF, F3 64, F4 through the link layer,
// validates each response with timeouts and retries, then enables streaming.
module ps2_init_sequencer
  import ps2_pkg::*;
#(
  parameter int ACK_TIMEOUT_CYC = 1000000,
  parameter int BAT_TIMEOUT_CYC = 50000000,
  parameter int MAX_RETRY       = 3
) (
  input  logic       iCLK_50,
  input  logic       iRST_n,
  input  logic       iSTART,
  output logic [7:0] oTX_DATA,
  output logic       oTX_REQ,
  input  logic       iTX_BUSY,
  input  logic       iTX_DONE,
  input  logic       iTX_ERR,
  input  logic [7:0] iRX_DATA,
  input  logic       iRX_VALID,
  output logic       oSTREAM_EN,
  output logic       oBUSY,
  output logic       oFAIL,
  output logic [3:0] oSTATE,
  output logic [1:0] oRETRY
);

  localparam int              TMR_W    = $clog2(BAT_TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] BAT_LAST = TMR_W'(BAT_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  ps2_state_e       state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [1:0]       retry, retry_nxt;
  logic [7:0]       tx_data, tx_data_nxt;
  logic             tx_req, tx_req_nxt;
  logic [TMR_W-1:0] timer;
  logic             start_edge;

  ps2_start_sync u_start_sync (
    .clk        (iCLK_50),
    .rst_n      (iRST_n),
    .key_n      (iSTART),
    .start_edge (start_edge)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt   = state;
    idx_nxt     = idx;
    retry_nxt   = retry;
    tx_data_nxt = tx_data;
    tx_req_nxt  = 1'b0;

    unique case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start_edge) begin
          state_nxt = ST_SEND;
          idx_nxt   = 2'd0;
          retry_nxt = 2'd0;
        end
      end
      ST_SEND: begin
        if (!iTX_BUSY) begin
          tx_data_nxt = cmd_rom(idx);
          tx_req_nxt  = 1'b1;
          state_nxt   = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        // A failed transmit outranks a simultaneous done pulse.
        if (iTX_ERR)       state_nxt = ST_RETRY;
        else if (iTX_DONE) state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (iRX_VALID) begin
          if (iRX_DATA == RSP_ACK) state_nxt = (idx == 2'd0) ? ST_WAIT_BAT : ST_NEXT;
          else                     state_nxt = ST_RETRY;
        end else if (timer == ACK_LAST) begin
          state_nxt = ST_RETRY;
        end
      end
      ST_WAIT_BAT: begin
        // Unrelated bytes during self-test are ignored and do not stop the timer.
        if (iRX_VALID && iRX_DATA == RSP_BAT_OK)   state_nxt = ST_WAIT_ID;
        else if (iRX_VALID && iRX_DATA == RSP_ERR) state_nxt = ST_RETRY;
        else if (timer == BAT_LAST)                state_nxt = ST_RETRY;
      end
      ST_WAIT_ID: begin
        if (iRX_VALID)              state_nxt = (iRX_DATA == ID_MOUSE) ? ST_NEXT : ST_RETRY;
        else if (timer == ACK_LAST) state_nxt = ST_RETRY;
      end
      ST_RETRY: begin
        if (retry == RETRY_MAX) begin
          state_nxt = ST_FAIL;
        end else begin
          retry_nxt = retry + 2'd1;
          state_nxt = ST_SEND;
        end
      end
      ST_NEXT: begin
        if (idx == CMD_LAST) begin
          state_nxt = ST_DONE;
        end else begin
          idx_nxt   = idx + 2'd1;
          retry_nxt = 2'd0;
          state_nxt = ST_SEND;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= ST_IDLE;
      idx     <= 2'd0;
      retry   <= 2'd0;
      tx_data <= 8'h00;
      tx_req  <= 1'b0;
      timer   <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      retry   <= retry_nxt;
      tx_data <= tx_data_nxt;
      tx_req  <= tx_req_nxt;
      // Timer restarts on every state change and saturates while waiting.
      if (state_nxt != state)  timer <= '0;
      else if (timer != TMR_MAX) timer <= timer + TMR_W'(1);
    end
  end

  assign oTX_DATA   = tx_data;
  assign oTX_REQ    = tx_req;
  assign oSTATE     = state;
  assign oRETRY     = retry;
  assign oSTREAM_EN = (state == ST_DONE);
  assign oFAIL      = (state == ST_FAIL);
  assign oBUSY      = !(state inside {ST_IDLE, ST_DONE, ST_FAIL});

endmodule

// File: tb/tb_ps2_init_sequencer.sv
// Randomized scoreboard bench for ps2_init_sequencer with a PS/2 link/device model.
// Expected transmit bytes come from a per-command fault plan, not from the RTL.
module tb_ps2_init_sequencer;
  import ps2_pkg::*;

  localparam int ACK = 40;
  localparam int BAT = 120;
  localparam int MAXR = 3;

  typedef enum int {K_OK, K_TXERR, K_NAK, K_ERRB, K_JUNK, K_TIMEOUT,
                    K_BATFC, K_BATTO, K_BADID, K_IDTO} kind_e;
  typedef struct { logic [7:0] data; logic [1:0] retry; } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iSTART;
  logic [7:0] oTX_DATA;
  logic       oTX_REQ;
  logic       iTX_BUSY, iTX_DONE, iTX_ERR;
  logic [7:0] iRX_DATA;
  logic       iRX_VALID;
  logic       oSTREAM_EN, oBUSY, oFAIL;
  logic [3:0] oSTATE;
  logic [1:0] oRETRY;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] cmds [4] = '{8'hFF, 8'hF3, 8'h64, 8'hF4};
  int    nfault [4];
  kind_e fkind  [4][5];
  bit    lateack[4];
  exp_t  exp_q[$];
  int    case_id = 0;
  int    stray_cnt = 0;

  ps2_init_sequencer #(
    .ACK_TIMEOUT_CYC (ACK),
    .BAT_TIMEOUT_CYC (BAT),
    .MAX_RETRY       (MAXR)
  ) dut (
    .iCLK_50    (clk),
    .iRST_n     (rst_n),
    .iSTART     (iSTART),
    .oTX_DATA   (oTX_DATA),
    .oTX_REQ    (oTX_REQ),
    .iTX_BUSY   (iTX_BUSY),
    .iTX_DONE   (iTX_DONE),
    .iTX_ERR    (iTX_ERR),
    .iRX_DATA   (iRX_DATA),
    .iRX_VALID  (iRX_VALID),
    .oSTREAM_EN (oSTREAM_EN),
    .oBUSY      (oBUSY),
    .oFAIL      (oFAIL),
    .oSTATE     (oSTATE),
    .oRETRY     (oRETRY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    iRX_DATA  = b;
    iRX_VALID = 1'b1;
    gap(1);
    iRX_VALID = 1'b0;
  endtask

  // Reference model: each command is sent once plus once per planned fault;
  // more faults than retries allow means MAX+1 sends and then abort.
  task automatic model_case(output bit exp_done);
    exp_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int sends;
      sends = (nfault[i] > MAXR) ? MAXR + 1 : nfault[i] + 1;
      for (int a = 0; a < sends; a++) exp_q.push_back('{data: cmds[i], retry: 2'(a)});
      if (nfault[i] > MAXR) begin
        exp_done = 1'b0;
        break;
      end
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 4; i++) begin
      nfault[i]  = 0;
      lateack[i] = 1'b0;
      for (int a = 0; a < 5; a++) fkind[i][a] = K_OK;
    end
  endtask

  task automatic press();
    iSTART = 1'b0;
    gap(4);
    iSTART = 1'b1;
  endtask

  // Scoreboard monitor: every transmit request must match the next expected byte.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && oTX_REQ) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tx_req", {24'h0, oTX_DATA}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", {24'h0, oTX_DATA}, {24'h0, e.data});
          check("tx_retry", {30'h0, oRETRY}, {30'h0, e.retry});
        end
      end
    end
  end

  // Link layer plus mouse: answers each request according to the fault plan.
  int  cnt[4];
  int  seen_case = -1;
  int  stray_seen = 0;
  bit  tmo_pending = 1'b0;
  int  done_cyc = 0;

  task automatic serve(input logic [7:0] d);
    int    i;
    int    att;
    bit    found;
    kind_e k;
    logic [7:0] b;
    i = 0;
    found = 1'b0;
    if (case_id != seen_case) begin
      seen_case = case_id;
      for (int j = 0; j < 4; j++) cnt[j] = 0;
      tmo_pending = 1'b0;
    end
    // A resend after an ACK timeout: ACK cycles of waiting, then RETRY and SEND.
    if (tmo_pending) begin
      check("ack_timeout_interval", 32'(cyc - done_cyc), 32'(ACK + 2));
      tmo_pending = 1'b0;
    end
    for (int j = 0; j < 4; j++) if (cmds[j] == d) begin i = j; found = 1'b1; end
    check("tx_cmd_known", {31'h0, found}, 32'h1);
    att = cnt[i];
    cnt[i]++;
    k = (att < nfault[i] && att < 5) ? fkind[i][att] : K_OK;

    iTX_BUSY = 1'b1;
    gap(int'($urandom_range(1, 4)));
    if (k == K_TXERR) begin
      iTX_ERR  = 1'b1;
      iTX_DONE = 1'($urandom_range(0, 1));
      iTX_BUSY = 1'b0;
      gap(1);
      iTX_ERR  = 1'b0;
      iTX_DONE = 1'b0;
      iTX_BUSY = 1'b1;
      gap(int'($urandom_range(0, 3)));
      iTX_BUSY = 1'b0;
      return;
    end
    iTX_DONE = 1'b1;
    iTX_BUSY = 1'b0;
    gap(1);
    iTX_DONE = 1'b0;
    done_cyc = cyc;

    case (k)
      K_OK: begin
        if (lateack[i]) gap(ACK - 1);
        else            gap(int'($urandom_range(0, 5)));
        rx_byte(8'hFA);
        if (i == 0) begin
          gap(int'($urandom_range(0, 5)));
          if ($urandom_range(0, 1) == 1) begin
            b = 8'($urandom);
            while (b == 8'hAA || b == 8'hFC) b = 8'($urandom);
            rx_byte(b);
            gap(int'($urandom_range(0, 3)));
          end
          rx_byte(8'hAA);
          gap(int'($urandom_range(0, 5)));
          rx_byte(8'h00);
        end
      end
      K_NAK:  begin gap(int'($urandom_range(0, 5))); rx_byte(8'hFE); end
      K_ERRB: begin gap(int'($urandom_range(0, 5))); rx_byte(8'hFC); end
      K_JUNK: begin
        b = 8'($urandom);
        while (b == 8'hFA) b = 8'($urandom);
        gap(int'($urandom_range(0, 5)));
        rx_byte(b);
      end
      K_TIMEOUT: tmo_pending = 1'b1;
      K_BATFC: begin rx_byte(8'hFA); gap(int'($urandom_range(0, 5))); rx_byte(8'hFC); end
      K_BATTO: rx_byte(8'hFA);
      K_BADID: begin
        b = 8'($urandom);
        while (b == 8'h00) b = 8'($urandom);
        rx_byte(8'hFA);
        gap(int'($urandom_range(0, 3)));
        rx_byte(8'hAA);
        gap(int'($urandom_range(0, 3)));
        rx_byte(b);
      end
      K_IDTO: begin rx_byte(8'hFA); gap(int'($urandom_range(0, 3))); rx_byte(8'hAA); end
      default: ;
    endcase
  endtask

  initial begin : device
    iTX_BUSY  = 1'b0;
    iTX_DONE  = 1'b0;
    iTX_ERR   = 1'b0;
    iRX_DATA  = 8'h00;
    iRX_VALID = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        rx_byte(8'hFA);
      end else if (rst_n && oTX_REQ) begin
        serve(oTX_DATA);
      end
    end
  end

  task automatic run_case(input bit mid_press);
    bit exp_done;
    int n;
    case_id++;
    model_case(exp_done);
    press();
    n = 0;
    while (!oBUSY && n < 20) begin gap(1); n++; end
    check("start_sets_busy", {31'h0, oBUSY}, 32'h1);
    check("start_clears_fail", {31'h0, oFAIL}, 32'h0);
    check("start_clears_stream", {31'h0, oSTREAM_EN}, 32'h0);
    if (mid_press) begin
      gap(2);
      press();
    end
    n = 0;
    while (oBUSY && n < 8000) begin gap(1); n++; end
    check("case_finished_in_budget", {31'h0, (n < 8000)}, 32'h1);
    check("stream_en_final", {31'h0, oSTREAM_EN}, {31'h0, exp_done});
    check("fail_final", {31'h0, oFAIL}, {31'h0, !exp_done});
    gap(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  initial begin : main
    int n;
    rst_n  = 1'b0;
    iSTART = 1'b1;
    gap(3);
    check("rst_tx_req", {31'h0, oTX_REQ}, 32'h0);
    check("rst_tx_data", {24'h0, oTX_DATA}, 32'h0);
    check("rst_stream_en", {31'h0, oSTREAM_EN}, 32'h0);
    check("rst_busy", {31'h0, oBUSY}, 32'h0);
    check("rst_fail", {31'h0, oFAIL}, 32'h0);
    check("rst_state", {28'h0, oSTATE}, {28'h0, ST_IDLE});
    check("rst_retry", {30'h0, oRETRY}, 32'h0);
    rst_n = 1'b1;
    gap(5);

    // Happy path, with a second press mid-sequence that must be ignored.
    clear_plan();
    run_case(1'b1);
    stray_cnt++;
    gap(4);
    check("done_ignores_rx", {28'h0, oSTATE}, {28'h0, ST_DONE});
    check("done_stream_en_held", {31'h0, oSTREAM_EN}, 32'h1);

    // Resend requested once on F3.
    clear_plan();
    nfault[1] = 1; fkind[1][0] = K_NAK;
    run_case(1'b0);

    // F4 never acknowledged: four sends, then abort.
    clear_plan();
    nfault[3] = 4;
    for (int a = 0; a < 5; a++) fkind[3][a] = K_TIMEOUT;
    run_case(1'b0);

    // Self-test error after FF, restarting from the aborted state.
    clear_plan();
    nfault[0] = 1; fkind[0][0] = K_BATFC;
    run_case(1'b0);

    // Two link errors on 64 (sometimes coinciding with done), then success.
    clear_plan();
    nfault[2] = 2; fkind[2][0] = K_TXERR; fkind[2][1] = K_TXERR;
    run_case(1'b0);

    // ACKs arriving exactly on the timeout cycle must be accepted.
    clear_plan();
    lateack[1] = 1'b1; lateack[3] = 1'b1;
    run_case(1'b0);

    // Reset while waiting for the self-test result.
    clear_plan();
    nfault[0] = 1; fkind[0][0] = K_BATTO;
    case_id++;
    exp_q.push_back('{data: 8'hFF, retry: 2'd0});
    press();
    n = 0;
    while (oSTATE != ST_WAIT_BAT && n < 200) begin gap(1); n++; end
    check("reached_wait_bat", {28'h0, oSTATE}, {28'h0, ST_WAIT_BAT});
    gap(3);
    #2 rst_n = 1'b0;
    #1;
    check("abort_state", {28'h0, oSTATE}, {28'h0, ST_IDLE});
    check("abort_busy", {31'h0, oBUSY}, 32'h0);
    check("abort_tx_req", {31'h0, oTX_REQ}, 32'h0);
    check("abort_tx_data", {24'h0, oTX_DATA}, 32'h0);
    check("abort_retry", {30'h0, oRETRY}, 32'h0);
    check("abort_fail", {31'h0, oFAIL}, 32'h0);
    check("abort_stream_en", {31'h0, oSTREAM_EN}, 32'h0);
    gap(5);
    rst_n = 1'b1;
    gap(3 * BAT);
    check("abort_no_reissue", 32'(exp_q.size()), 32'h0);
    check("abort_stays_idle", {28'h0, oSTATE}, {28'h0, ST_IDLE});
    exp_q.delete();

    // Randomized fault plans.
    for (int c = 0; c < 14; c++) begin
      clear_plan();
      for (int i = 0; i < 4; i++) begin
        int r;
        r = int'($urandom_range(0, 9));
        nfault[i]  = (r < 5) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 4;
        lateack[i] = ($urandom_range(0, 5) == 0);
        for (int a = 0; a < 5; a++)
          fkind[i][a] = kind_e'($urandom_range(1, (i == 0) ? 9 : 5));
      end
      run_case(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
